pwm_channel_bank: RTL
=====================

# pwm_channel_bank

Parametrised bank of independent PWM channels with double-buffered duty cycles. Each new duty-cycle set takes effect only at a PWM period boundary, so outputs never glitch mid-period. Optionally, duty changes ramp linearly instead of stepping. It drives on-board RGB LEDs and status indicators, and supersedes the fixed three-channel 8-bit controller.

## Interface
Parameters:
- CHANNELS, 3: number of PWM outputs (≥1).
- DC_WIDTH, 8: duty/counter width in bits (2..16). Period is 2^DC_WIDTH−1 ticks.
- PRESCALE, 1: clock cycles per counter tick (≥1). 1 = tick every cycle.

Ports:
- clk_in  input  1  system clock.
- rst_in  input  1  reset; synchronous, active-high.
- dc_in  input  CHANNELS*DC_WIDTH  target duty per channel; channel i occupies bits [i*DC_WIDTH +: DC_WIDTH].
- load_in  input  1  single-cycle strobe; captures all of dc_in as the pending set.
- sig_out  output  CHANNELS  registered PWM outputs; bit i belongs to channel i.
- period_start_out  output  1  one-cycle pulse, registered, aligned with the first tick of each period.
- settled_out  output  1  high when every active duty equals its pending duty.

## Operation
- Prescaler: prs counts 0..PRESCALE−1. tick is asserted when prs==PRESCALE−1. When PRESCALE==1, tick is constantly 1.
- Period counter cnt (DC_WIDTH bits): on each tick, cnt advances 0,1,…,2^DC_WIDTH−2, then wraps to 0. It never holds all-ones.
- boundary = tick && cnt==2^DC_WIDTH−2. This is the last tick of a period.
- Each channel has two registers:
  - pending[i]: loaded from dc_in on load_in, in any cycle.
  - active[i]: updated only on boundary.
- On boundary, without fade: active[i] ← pending[i].
  - If load_in coincides with boundary, active[i] ← dc_in slice directly (bypass), and pending[i] ← the same value.
- Output compare: sig_out[i] ← (cnt < active[i]), registered.
  - active = 0 gives constant low.
  - active = 2^DC_WIDTH−1 gives constant high.
  - Duty = active/(2^DC_WIDTH−1).
- Compare uses the post-boundary active value: the first cycle of the new period already reflects the new duty.
- Multiple load_in pulses within one period: the last one wins; earlier ones are discarded.
- All channels share cnt; there is no phase stagger.
- Reset mid-period: all state returns to reset values on the next edge. The counter restarts at 0.

## Timing
- Reset values:
  - prs=0, cnt=0, pending=0, active=0.
  - sig_out=0, period_start_out=0, settled_out=1.
- Output latency: sig_out and period_start_out lag cnt by exactly 1 clock.
- period_start_out is high for the single clk cycle in which registered outputs reflect cnt==0 after a tick. Period = (2^DC_WIDTH−1)*PRESCALE cycles.
- load_in → duty visible on sig_out: 1 clock after the next boundary.
  - Worst case: one full period + 1 cycle.
  - Best case, load_in on boundary: 1 cycle.
- settled_out is combinational from registers:
  - Drops in the cycle after a load_in that changes any pending value.
  - Rises in the cycle after the boundary that equalises all channels.

## Configuration
- PWM_FADE_EN defined: on each boundary, each active[i] moves by exactly 1 LSB toward pending[i] and holds once equal.
  - A full-scale change therefore takes 2^DC_WIDTH−1 periods.
  - The load_in bypass on boundary still applies, but to pending only; that boundary's step is taken toward the new value.
  - settled_out stays low for the whole ramp.
- PWM_FADE_EN undefined: active steps to pending in one boundary, as above. No ramp logic is synthesised.

## Test plan
Common configuration: CHANNELS=3, DC_WIDTH=4 (period 15), PRESCALE=1, fade off unless stated.
- Reset then hold: load ch0=0, ch1=15, ch2=5 on one strobe. After the next boundary:
  - ch0 constant 0.
  - ch1 constant 1.
  - ch2 high exactly 5 of each 15 cycles, starting on the period_start_out cycle.
  - period_start_out pulses every 15 cycles.
- Mid-period update: ch2 is 5. Load 10 at cnt=3. The current period keeps 5 high cycles; the next period has 10. settled_out is low from load+1 until the boundary+1.
- Coincident load and boundary: load 12 exactly on boundary. The very next period shows 12 high cycles.
- Last-wins: within one period, load 3, then 9, then 7. The next period shows 7.
- Prescale: PRESCALE=4, duty 5. Outputs are high for 20 cycles per 60-cycle period.
- Fade (PWM_FADE_EN): ch0 at 0, load 4.
  - Successive periods show 1, 2, 3, 4 high cycles.
  - settled_out rises 1 cycle after the 4th boundary.
  - A rst_in pulse mid-ramp returns all outputs to 0 and settled_out to 1.

Source files
------------

// File: rtl/pwm_channel_bank.sv
// -----------------------------------------------------------------------------
// pwm_channel_bank
//
// A bank of independent PWM channels. All channels share one prescaler and one
// period counter. Each channel has a double-buffered duty cycle. A new duty set
// reaches the compare logic only at a period boundary, so no output glitches
// part-way through a period.
//
// Optional feature, controlled by the macro PWM_FADE_EN:
//   defined   - At each boundary, every active duty moves 1 LSB toward its
//               pending duty. The output therefore ramps linearly.
//   undefined - Every active duty steps straight to its pending duty at the
//               boundary. No ramp logic is built.
//
// Parameters:
//   CHANNELS  number of PWM outputs (>=1)
//   DC_WIDTH  duty/counter width (2..16). The period is 2^DC_WIDTH-1 ticks.
//   PRESCALE  clock cycles per counter tick (>=1)
//
// Ports:
//   clk_in            system clock
//   rst_in            synchronous, active-high reset
//   dc_in             target duties; channel i is dc_in[i*DC_WIDTH +: DC_WIDTH]
//   load_in           single-cycle strobe; captures dc_in as the pending set
//   sig_out           registered PWM outputs, one bit per channel
//   period_start_out  registered one-cycle pulse on the first cycle of a period
//   settled_out       high when every active duty equals its pending duty
// -----------------------------------------------------------------------------
module pwm_channel_bank #(
    parameter int CHANNELS = 3,
    parameter int DC_WIDTH = 8,
    parameter int PRESCALE = 1
) (
    input  logic                         clk_in,
    input  logic                         rst_in,
    input  logic [CHANNELS*DC_WIDTH-1:0] dc_in,
    input  logic                         load_in,
    output logic [CHANNELS-1:0]          sig_out,
    output logic                         period_start_out,
    output logic                         settled_out
);

    localparam int PRS_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PRS_W-1:0]    PRS_LAST = PRS_W'(PRESCALE - 1);
    // The counter never reaches all-ones, so the last count is 2^DC_WIDTH-2.
    localparam logic [DC_WIDTH-1:0] CNT_LAST = {{(DC_WIDTH-1){1'b1}}, 1'b0};

    logic [PRS_W-1:0]    prs_q, prs_d;
    logic [DC_WIDTH-1:0] cnt_q, cnt_d;
    logic                tick;
    logic                boundary;
    // High only in the first cycle that cnt sits at 0, so a prescaled period
    // gives a single start pulse and not PRESCALE of them.
    logic                fresh_q;
    logic                period_start_q;

    logic [CHANNELS-1:0][DC_WIDTH-1:0] pending_q, pending_d;
    logic [CHANNELS-1:0][DC_WIDTH-1:0] active_q, active_d;
    logic [CHANNELS-1:0]               sig_q, sig_d;
    logic [CHANNELS-1:0]               equal;

    // With PRESCALE==1, PRS_LAST is 0 and prs_q stays at 0. tick is then
    // constantly high.
    assign tick     = (prs_q == PRS_LAST);
    assign boundary = tick && (cnt_q == CNT_LAST);

    always_comb begin
        prs_d = prs_q;
        cnt_d = cnt_q;
        if (tick) begin
            prs_d = '0;
            cnt_d = boundary ? '0 : cnt_q + 1'b1;
        end else begin
            prs_d = prs_q + 1'b1;
        end
    end

    generate
        for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_ch
            logic [DC_WIDTH-1:0] dc_slice;
            assign dc_slice = dc_in[gi*DC_WIDTH +: DC_WIDTH];

            // A load on the boundary cycle feeds the boundary update directly.
            // This works because the update reads pending_d, not pending_q.
            assign pending_d[gi] = load_in ? dc_slice : pending_q[gi];

`ifdef PWM_FADE_EN
            assign active_d[gi] = !boundary ? active_q[gi] :
                                  (active_q[gi] < pending_d[gi]) ? active_q[gi] + 1'b1 :
                                  (active_q[gi] > pending_d[gi]) ? active_q[gi] - 1'b1 :
                                  active_q[gi];
`else
            assign active_d[gi] = boundary ? pending_d[gi] : active_q[gi];
`endif

            // active_q already holds the post-boundary duty when cnt_q is 0.
            // The first cycle of a new period therefore shows the new duty.
            assign sig_d[gi] = (cnt_q < active_q[gi]);
            assign equal[gi] = (active_q[gi] == pending_q[gi]);
        end
    endgenerate

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            prs_q          <= '0;
            cnt_q          <= '0;
            fresh_q        <= 1'b1;
            period_start_q <= 1'b0;
            pending_q      <= '0;
            active_q       <= '0;
            sig_q          <= '0;
        end else begin
            prs_q          <= prs_d;
            cnt_q          <= cnt_d;
            fresh_q        <= boundary;
            period_start_q <= fresh_q;
            pending_q      <= pending_d;
            active_q       <= active_d;
            sig_q          <= sig_d;
        end
    end

    assign sig_out          = sig_q;
    assign period_start_out = period_start_q;
    assign settled_out      = &equal;

endmodule
